// File: rtl/mesi_snoop_bus.sv
// mesi_snoop_bus
// Serialised MESI coherence engine for N_CORES private direct-mapped caches
// that share one snooping bus. A round-robin arbiter picks one core request at
// a time. The engine then walks LOOKUP -> [VICTIM_WB] -> [BUS] -> DONE,
// applying the requester-side transition, broadcasting the bus command to the
// snoopers, and flagging writebacks and memory aborts.
module mesi_snoop_bus #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 4,
    parameter int INDEX_W = 2,
    localparam int TAG_W  = ADDR_W - INDEX_W,
    localparam int OWN_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_CORES-1:0]         req_valid,
    input  logic [N_CORES-1:0]         req_op,
    input  logic [N_CORES*ADDR_W-1:0]  req_addr,
    output logic [N_CORES-1:0]         req_done,
    output logic                       bus_valid,
    output logic [1:0]                 bus_cmd,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [OWN_W-1:0]           bus_owner,
    output logic                       writeback,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic                       abort_memory,
    input  logic [OWN_W-1:0]           dbg_core,
    input  logic [INDEX_W-1:0]         dbg_index,
    output logic [1:0]                 dbg_state,
    output logic [TAG_W-1:0]           dbg_tag
);

    localparam int LINES = 32'd1 << INDEX_W;

    // Line states
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    // Bus commands
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RM   = 2'b01;
    localparam logic [1:0] CMD_WM   = 2'b10;
    localparam logic [1:0] CMD_INV  = 2'b11;

    typedef enum logic [2:0] {
        FSM_IDLE      = 3'd0,
        FSM_LOOKUP    = 3'd1,
        FSM_VICTIM_WB = 3'd2,
        FSM_BUS       = 3'd3,
        FSM_DONE      = 3'd4
    } fsm_t;

    // Snooper-side MESI transition for a line whose tag matches the bus address.
    // A foreign M can never coexist with an INV requester (the requester is in S),
    // so M only reacts to RM and WM.
    function automatic logic [1:0] snoop_next(input logic [1:0] st, input logic [1:0] cmd);
        logic [1:0] nxt;
        nxt = st;
        case (st)
            ST_S: begin
                if (cmd == CMD_WM || cmd == CMD_INV) nxt = ST_I;
                else                                 nxt = st;
            end
            ST_E: begin
                if (cmd == CMD_RM)                        nxt = ST_S;
                else if (cmd == CMD_WM || cmd == CMD_INV) nxt = ST_I;
                else                                      nxt = st;
            end
            ST_M: begin
                if (cmd == CMD_RM)      nxt = ST_S;
                else if (cmd == CMD_WM) nxt = ST_I;
                else                    nxt = st;
            end
            default: nxt = st;
        endcase
        return nxt;
    endfunction

    // Cache arrays
    logic [1:0]       line_state_r [N_CORES][LINES];
    logic [TAG_W-1:0] line_tag_r   [N_CORES][LINES];

    // Transaction context
    fsm_t             fsm_r, fsm_s;
    logic [OWN_W-1:0] owner_r;
    logic [OWN_W-1:0] last_grant_r;
    logic             op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]       cmd_r, cmd_s;
    logic [1:0]       final_r, final_s;

    // Arbiter
    logic             grant_found_s;
    logic [OWN_W-1:0] grant_idx_s;
    logic             grant_op_s;
    logic [ADDR_W-1:0] grant_addr_s;

    // Lookup of the latched request
    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [1:0]         own_state_s;
    logic [TAG_W-1:0]   own_tag_s;
    logic               hit_s;
    logic               shared_s;
    logic               snoop_dirty_s;

    // Next values of the registered outputs
    logic               issue_bus_s;
    logic [1:0]         issue_cmd_s;
    logic [N_CORES-1:0] req_done_s;
    logic               bus_valid_s;
    logic [1:0]         bus_cmd_s;
    logic [ADDR_W-1:0]  bus_addr_s;
    logic [OWN_W-1:0]   bus_owner_s;
    logic               writeback_s;
    logic [ADDR_W-1:0]  wb_addr_s;
    logic               abort_s;

    // Registered outputs
    logic [N_CORES-1:0] req_done_r;
    logic               bus_valid_r;
    logic [1:0]         bus_cmd_r;
    logic [ADDR_W-1:0]  bus_addr_r;
    logic [OWN_W-1:0]   bus_owner_r;
    logic               writeback_r;
    logic [ADDR_W-1:0]  wb_addr_r;
    logic               abort_r;

    // Round-robin pick, searching from the core after the last one served.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            if (!grant_found_s && req_valid[OWN_W'((int'(last_grant_r) + i) % N_CORES)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = OWN_W'((int'(last_grant_r) + i) % N_CORES);
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Select op and address of the core the arbiter picked.
    always_comb begin
        grant_op_s   = 1'b0;
        grant_addr_s = '0;
        for (int c = 0; c < N_CORES; c++) begin
            if (OWN_W'(c) == grant_idx_s) begin
                grant_op_s   = req_op[c];
                grant_addr_s = req_addr[c*ADDR_W +: ADDR_W];
            end else begin
                grant_op_s   = grant_op_s;
            end
        end
    end

    // Requester hit test plus shared / dirty-holder detection across the other caches.
    always_comb begin
        idx_s         = addr_r[INDEX_W-1:0];
        tag_s         = addr_r[ADDR_W-1:INDEX_W];
        own_state_s   = line_state_r[owner_r][idx_s];
        own_tag_s     = line_tag_r[owner_r][idx_s];
        hit_s         = (own_state_s != ST_I) && (own_tag_s == tag_s);
        shared_s      = 1'b0;
        snoop_dirty_s = 1'b0;
        for (int c = 0; c < N_CORES; c++) begin
            if (c != int'(owner_r) && line_state_r[c][idx_s] != ST_I &&
                line_tag_r[c][idx_s] == tag_s) begin
                shared_s = 1'b1;
                if (line_state_r[c][idx_s] == ST_M) snoop_dirty_s = 1'b1;
                else                                snoop_dirty_s = snoop_dirty_s;
            end else begin
                shared_s = shared_s;
            end
        end
    end

    // Next state, requester decision and next values of every registered output.
    always_comb begin
        fsm_s       = fsm_r;
        cmd_s       = cmd_r;
        final_s     = final_r;
        issue_bus_s = 1'b0;
        issue_cmd_s = CMD_NONE;
        req_done_s  = '0;
        writeback_s = 1'b0;
        wb_addr_s   = '0;
        abort_s     = 1'b0;
        bus_valid_s = 1'b0;
        bus_cmd_s   = CMD_NONE;
        bus_addr_s  = '0;
        bus_owner_s = '0;
        case (fsm_r)
            FSM_IDLE: begin
                if (grant_found_s) fsm_s = FSM_LOOKUP;
                else               fsm_s = FSM_IDLE;
            end
            FSM_LOOKUP: begin
                if (hit_s) begin
                    if (!op_r) begin
                        cmd_s   = CMD_NONE;
                        final_s = own_state_s;
                        fsm_s   = FSM_DONE;
                        req_done_s[owner_r] = 1'b1;
                    end else if (own_state_s == ST_S) begin
                        cmd_s       = CMD_INV;
                        final_s     = ST_M;
                        fsm_s       = FSM_BUS;
                        issue_bus_s = 1'b1;
                        issue_cmd_s = CMD_INV;
                    end else begin
                        cmd_s   = CMD_NONE;
                        final_s = ST_M;
                        fsm_s   = FSM_DONE;
                        req_done_s[owner_r] = 1'b1;
                    end
                end else begin
                    if (op_r) begin
                        cmd_s   = CMD_WM;
                        final_s = ST_M;
                    end else begin
                        cmd_s   = CMD_RM;
                        final_s = shared_s ? ST_S : ST_E;
                    end
                    // A dirty resident line must reach memory before it is replaced.
                    if (own_state_s == ST_M) begin
                        fsm_s       = FSM_VICTIM_WB;
                        writeback_s = 1'b1;
                        wb_addr_s   = {own_tag_s, idx_s};
                    end else begin
                        fsm_s       = FSM_BUS;
                        issue_bus_s = 1'b1;
                        issue_cmd_s = op_r ? CMD_WM : CMD_RM;
                    end
                end
            end
            FSM_VICTIM_WB: begin
                fsm_s       = FSM_BUS;
                issue_bus_s = 1'b1;
                issue_cmd_s = cmd_r;
            end
            FSM_BUS: begin
                fsm_s = FSM_DONE;
                req_done_s[owner_r] = 1'b1;
            end
            FSM_DONE: begin
                fsm_s = FSM_IDLE;
            end
            default: begin
                fsm_s = FSM_IDLE;
            end
        endcase

        if (issue_bus_s) begin
            bus_valid_s = 1'b1;
            bus_cmd_s   = issue_cmd_s;
            bus_addr_s  = addr_r;
            bus_owner_s = owner_r;
            // A foreign M holder supplies the data and flushes it during the bus cycle.
            if (snoop_dirty_s && issue_cmd_s != CMD_INV) begin
                writeback_s = 1'b1;
                wb_addr_s   = addr_r;
                abort_s     = 1'b1;
            end else begin
                abort_s     = 1'b0;
            end
        end else begin
            bus_valid_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_r <= FSM_IDLE;
        end else begin
            fsm_r <= fsm_s;
        end
    end

    // Transaction context, arbitration pointer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_r      <= '0;
            last_grant_r <= OWN_W'(N_CORES - 1);
            op_r         <= 1'b0;
            addr_r       <= '0;
            cmd_r        <= CMD_NONE;
            final_r      <= ST_I;
            req_done_r   <= '0;
            bus_valid_r  <= 1'b0;
            bus_cmd_r    <= CMD_NONE;
            bus_addr_r   <= '0;
            bus_owner_r  <= '0;
            writeback_r  <= 1'b0;
            wb_addr_r    <= '0;
            abort_r      <= 1'b0;
        end else begin
            cmd_r       <= cmd_s;
            final_r     <= final_s;
            req_done_r  <= req_done_s;
            bus_valid_r <= bus_valid_s;
            bus_cmd_r   <= bus_cmd_s;
            bus_addr_r  <= bus_addr_s;
            bus_owner_r <= bus_owner_s;
            writeback_r <= writeback_s;
            wb_addr_r   <= wb_addr_s;
            abort_r     <= abort_s;
            if (fsm_r == FSM_IDLE && grant_found_s) begin
                owner_r <= grant_idx_s;
                op_r    <= grant_op_s;
                addr_r  <= grant_addr_s;
            end
            if (fsm_r == FSM_DONE) begin
                last_grant_r <= owner_r;
            end
        end
    end

    // Line arrays: snoopers update at the end of BUS, the requester fills at the end of DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CORES; c++) begin
                for (int l = 0; l < LINES; l++) begin
                    line_state_r[c][l] <= ST_I;
                    line_tag_r[c][l]   <= '0;
                end
            end
        end else begin
            if (fsm_r == FSM_BUS) begin
                for (int c = 0; c < N_CORES; c++) begin
                    if (c != int'(owner_r) && line_tag_r[c][idx_s] == tag_s) begin
                        line_state_r[c][idx_s] <= snoop_next(line_state_r[c][idx_s], cmd_r);
                    end
                end
            end
            if (fsm_r == FSM_DONE) begin
                line_state_r[owner_r][idx_s] <= final_r;
                line_tag_r[owner_r][idx_s]   <= tag_s;
            end
        end
    end

    assign req_done     = req_done_r;
    assign bus_valid    = bus_valid_r;
    assign bus_cmd      = bus_cmd_r;
    assign bus_addr     = bus_addr_r;
    assign bus_owner    = bus_owner_r;
    assign writeback    = writeback_r;
    assign wb_addr      = wb_addr_r;
    assign abort_memory = abort_r;

    assign dbg_state = line_state_r[dbg_core][dbg_index];
    assign dbg_tag   = line_tag_r[dbg_core][dbg_index];

endmodule
